pipe_stage_buf: RTL and testbench

//  Parametrised elastic stage register between adjacent CPU pipeline stages (D->E, E->M, M->W).

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_sat_cnt.sv | 39 +++
 rtl/pipe_stage_buf.sv | 167 ++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//  Shared definitions for the pipeline stage buffers.
//  - NOP_WORD     : the instruction word a bubble carries in each lane
//  - buf_state_e  : occupancy state of a stage buffer, encoded as {skid_v, main_v}
//  - DEF_LANES and lane index names for the standard stage payload layout
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0;

   // Standard payload: imm32, rs, rt, PC, instr (lane k = data[k*W +: W])
   localparam int DEF_LANES = 5;
   localparam int LANE_IMM  = 0;
   localparam int LANE_RS   = 1;
   localparam int LANE_RT   = 2;
   localparam int LANE_PC   = 3;
   localparam int LANE_INS  = 4;

   // Bit 1 = skid entry valid, bit 0 = main entry valid.
   // {1,0} cannot occur: the skid entry only fills while main is held.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } buf_state_e;

   // True when the state encoding says the main register holds a live word.
   function automatic logic state_main_v(input buf_state_e s);
      return s[0];
   endfunction

   // True when the state encoding says the skid register holds a live word.
   function automatic logic state_skid_v(input buf_state_e s);
      return s[1];
   endfunction

endpackage : pipe_pkg

// File: rtl/pipe_sat_cnt.sv
// -----------------------------------------------------------------------------
// pipe_sat_cnt
//  CNT_W-wide up-counter that sticks at all-ones instead of wrapping.
//  Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high clear (wins over inc)
//   inc    in   count this cycle
//   cnt    out  current count
// -----------------------------------------------------------------------------
module pipe_sat_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule : pipe_sat_cnt

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//  Elastic register between two CPU pipeline stages. Carries LANES payload
//  words of W bits under a valid/ready handshake. A main register drives the
//  output and a one-word skid register absorbs the word that arrives in the
//  cycle downstream stalls, so in_ready can come straight from a flop.
//  flush turns the stage into a bubble (all-zero payload = NOP).
//
//  Build option: define PIPE_PERF_CNT_EN to build the stall/bubble performance
//  counters; otherwise stall_cnt and bubble_cnt are tied to 0.
//
//  Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   flush       in   kill stage contents this cycle
//   in_valid    in   upstream offers in_data
//   in_ready    out  stage can accept (registered)
//   in_data     in   W*LANES payload, lane k = in_data[k*W +: W]
//   out_valid   out  out_data is live
//   out_ready   in   downstream consumes this cycle
//   out_data    out  W*LANES payload, zero whenever out_valid == 0
//   stall_cnt   out  cycles with out_valid && !out_ready (saturating)
//   bubble_cnt  out  cycles with !out_valid (saturating)
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  ST_EMPTY  | nothing held, out_valid=0, in_ready=1
//  ST_ONE    | main holds the output word, skid empty, in_ready=1
//  ST_FULL   | main holds output, skid holds the next word, in_ready=0
// -----------------------------------------------------------------------------
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int W     = 32,
   parameter int LANES = DEF_LANES,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W*LANES-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W*LANES-1:0] out_data,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   bubble_cnt
);

   localparam int DW = W * LANES;

   // Every lane of a bubble carries the NOP instruction word.
   localparam logic [DW-1:0] NOP_PAYLOAD = {LANES{W'(NOP_WORD)}};

   buf_state_e    state_q;
   buf_state_e    state_d;
   logic [DW-1:0] main_data_q;
   logic [DW-1:0] main_data_d;
   logic [DW-1:0] skid_data_q;
   logic [DW-1:0] skid_data_d;
   logic          in_ready_q;
   logic          in_ready_d;

   logic          accept;
   logic          consume;

   assign accept  = in_valid && in_ready_q;
   assign consume = state_main_v(state_q) && out_ready;

   // State register. Reset wins over flush and everything else.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         main_data_q <= NOP_PAYLOAD;
         skid_data_q <= NOP_PAYLOAD;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         skid_data_q <= skid_data_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) state_d = ST_ONE;
            end
            ST_ONE: begin
               if (accept && !consume)      state_d = ST_FULL;
               else if (consume && !accept) state_d = ST_EMPTY;
            end
            ST_FULL: begin
               // in_ready is low here, so accept cannot happen.
               if (consume) state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Datapath and ready. Whole payload moves as one unit; main is zeroed
   // whenever it goes empty so out_data reads as NOP while out_valid is low.
   always_comb begin
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         main_data_d = NOP_PAYLOAD;
         skid_data_d = NOP_PAYLOAD;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) main_data_d = in_data;
            end
            ST_ONE: begin
               if (accept && consume)  main_data_d = in_data;
               else if (accept)        skid_data_d = in_data;
               else if (consume)       main_data_d = NOP_PAYLOAD;
            end
            ST_FULL: begin
               // Older skid word advances before any newer input.
               if (consume) begin
                  main_data_d = skid_data_q;
                  skid_data_d = NOP_PAYLOAD;
               end
            end
            default: begin
               main_data_d = NOP_PAYLOAD;
               skid_data_d = NOP_PAYLOAD;
            end
         endcase
      end
      // Registered ready: low exactly while the skid entry will be occupied.
      in_ready_d = !state_skid_v(state_d);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = state_main_v(state_q);
   assign out_data  = main_data_q;

`ifdef PIPE_PERF_CNT_EN
   pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid && !out_ready),
      .cnt   (stall_cnt)
   );

   pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!out_valid),
      .cnt   (bubble_cnt)
   );
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//  Scoreboard bench for pipe_stage_buf. The reference model is a FIFO of
//  capacity two: accepted words are queued, a consume removes the oldest,
//  flush/reset empty it. in_ready is expected whenever fewer than two words
//  are held; out_valid whenever at least one is held.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

   localparam int W     = 32;
   localparam int LANES = 5;
   localparam int CNT_W = 4;
   localparam int DW    = W * LANES;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    in_data;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;

   always #5 clk = ~clk;

   pipe_stage_buf #(.W(W), .LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [DW-1:0]    exp_q[$];
   logic             started    = 1'b0;
   logic             ready_pred = 1'b0;
   logic             valid_pred = 1'b0;
   logic [CNT_W-1:0] stall_m    = '0;
   logic [CNT_W-1:0] bubble_m   = '0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: mid-cycle, compare DUT outputs with the model and retire the
   // word the DUT hands over when downstream is ready.
   always @(negedge clk) begin
      if (started) begin
         ready_pred = (exp_q.size() < 2);
         valid_pred = (exp_q.size() > 0);
         check("in_ready", DW'(in_ready), DW'(ready_pred));
         check("out_valid", DW'(out_valid), DW'(valid_pred));
         if (!valid_pred) begin
            check("out_data_idle", out_data, '0);
         end else begin
            check("out_data", out_data, exp_q[0]);
            if (out_ready && !reset) void'(exp_q.pop_front());
         end
`ifdef PIPE_PERF_CNT_EN
         check("stall_cnt", DW'(stall_cnt), DW'(stall_m));
         check("bubble_cnt", DW'(bubble_cnt), DW'(bubble_m));
`else
         check("stall_cnt_off", DW'(stall_cnt), '0);
         check("bubble_cnt_off", DW'(bubble_cnt), '0);
`endif
      end
   end

   // Stimulus side of the scoreboard: on each edge, apply reset/flush and
   // queue any word the model says is accepted.
   always @(posedge clk) begin
      if (reset) begin
         exp_q.delete();
         started  = 1'b1;
         stall_m  = '0;
         bubble_m = '0;
      end else if (started) begin
         if (valid_pred && !out_ready && stall_m != '1)  stall_m++;
         if (!valid_pred && bubble_m != '1)              bubble_m++;
         if (flush) exp_q.delete();
         else if (in_valid && ready_pred) exp_q.push_back(in_data);
      end
   end

   task automatic drive(input logic rst, input logic fl, input logic iv,
                        input logic [DW-1:0] d, input logic ordy);
      reset     = rst;
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   // Payload with a recognisable instruction lane and random other lanes.
   function automatic logic [DW-1:0] mkw(input logic [31:0] tag);
      return {tag, $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      logic [DW-1:0] c_word;

      // Reset with in_valid high: nothing may be captured.
      drive(1, 0, 1, mkw(32'h99), 0);
      drive(1, 0, 1, mkw(32'h98), 0);

      // Streaming 1..5 with downstream always ready.
      for (int i = 1; i <= 5; i++) drive(0, 0, 1, mkw(i), 1);
      repeat (2) drive(0, 0, 0, '0, 1);

      // Back-pressure: A, B fill the stage, C is held off, then drained in order.
      drive(0, 0, 1, mkw(32'hA), 0);
      drive(0, 0, 1, mkw(32'hB), 0);
      c_word = mkw(32'hC);
      repeat (2) drive(0, 0, 1, c_word, 0);
      repeat (2) drive(0, 0, 1, c_word, 1);
      repeat (2) drive(0, 0, 0, '0, 1);

      // Flush while FULL with D offered: D must never appear.
      drive(0, 0, 1, mkw(32'hA2), 0);
      drive(0, 0, 1, mkw(32'hB2), 0);
      drive(0, 1, 1, mkw(32'hD), 0);
      repeat (2) drive(0, 0, 0, '0, 1);

      // Reset and flush together while FULL, then accept E.
      drive(0, 0, 1, mkw(32'hA3), 0);
      drive(0, 0, 1, mkw(32'hB3), 0);
      drive(1, 1, 1, mkw(32'hF0), 0);
      drive(0, 0, 1, mkw(32'hE), 1);
      repeat (2) drive(0, 0, 0, '0, 1);

      // Stall saturation: one word held for 20 cycles.
      drive(1, 0, 0, '0, 0);
      drive(0, 0, 0, '0, 0);
      drive(0, 0, 1, mkw(32'h51), 0);
      repeat (20) drive(0, 0, 0, '0, 0);
`ifdef PIPE_PERF_CNT_EN
      check("stall_sat", DW'(stall_cnt), DW'(4'hF));
`endif
      repeat (2) drive(0, 0, 0, '0, 1);

      // Randomised traffic with occasional flush and reset.
      for (int i = 0; i < 800; i++) begin
         drive(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 4),
               ($urandom_range(0, 99) < 70), mkw($urandom()),
               ($urandom_range(0, 99) < 60));
      end
      repeat (4) drive(0, 0, 0, '0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_pipe_stage_buf
